// File: rtl/ct_spsram_pkg.sv
// ct_spsram_pkg: clear-FSM state encoding and group-size helper for ct_spsram_clr
package ct_spsram_pkg;
  typedef enum logic {CLR_IDLE = 1'b0, CLR_CLEAR = 1'b1} clr_state_e;
  function automatic int group_size(input int data_width, input int we_width);
    return data_width / we_width;
  endfunction
endpackage

// File: rtl/ct_spsram_clr_fsm.sv
// ct_spsram_clr_fsm: sweeps every address with a clear write after reset or clr_req, then pulses done
module ct_spsram_clr_fsm import ct_spsram_pkg::*; #(
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  clr_we
);
  clr_state_e            state, state_n;
  logic [ADDR_WIDTH-1:0] cnt, cnt_n;
  logic                  done_n, last;
  assign busy     = state == CLR_CLEAR;
  assign clr_we   = busy;
  assign clr_addr = cnt;
  always_ff @(posedge clk)
    if (rst) begin
      state <= CLR_CLEAR;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      done  <= done_n;
    end
  always_comb begin
    last    = busy && cnt == '1;
    state_n = clr_req ? CLR_CLEAR : last ? CLR_IDLE : state;
    cnt_n   = (clr_req || !busy) ? '0 : cnt + 1'b1;
    done_n  = last && !clr_req;
  end
endmodule

// File: rtl/ct_spsram_clr.sv
// ct_spsram_clr: single-port SRAM with grouped write enables and a hardware clear engine; CT_SPSRAM_OUTREG_EN adds an output register (2-cycle read)
module ct_spsram_clr import ct_spsram_pkg::*; #(
  parameter int                    ADDR_WIDTH = 7,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    WE_WIDTH   = 16,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [WE_WIDTH-1:0]   WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  input  logic                  CLR_REQ,
  output logic                  CLR_BUSY,
  output logic                  CLR_DONE
);
  localparam int G = group_size(DATA_WIDTH, WE_WIDTH);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] q_rd;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_we, acc;
  assign acc = !RST && !CLR_BUSY && !CEN;
  ct_spsram_clr_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_fsm (
    .clk(CLK), .rst(RST), .clr_req(CLR_REQ), .busy(CLR_BUSY),
    .done(CLR_DONE), .clr_addr(clr_addr), .clr_we(clr_we)
  );
  always_ff @(posedge CLK)
    if (clr_we) mem[clr_addr] <= INIT_VALUE;
    else if (acc && !GWEN)
      for (int i = 0; i < WE_WIDTH; i++)
        if (!WEN[i]) mem[A][i*G +: G] <= D[i*G +: G];
  always_ff @(posedge CLK)
    if (RST) q_rd <= '0;
    else if (acc && GWEN) q_rd <= mem[A];
`ifdef CT_SPSRAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] q_out;
  always_ff @(posedge CLK) q_out <= RST ? '0 : q_rd;
  assign Q = q_out;
`else
  assign Q = q_rd;
`endif
endmodule

// File: tb/tb_ct_spsram_clr.sv
// tb_ct_spsram_clr: directed and random checks of ct_spsram_clr against a behavioural model
module tb_ct_spsram_clr;
  localparam int DEPTH = 128;
  localparam int G = 1;
  logic clk = 1'b0, rst = 1'b1, cen = 1'b1, gwen = 1'b1, clr_req = 1'b0;
  logic [6:0] a = '0;
  logic [15:0] wen = '1, d = '0, q;
  logic busy, done;
  logic [6:0] a2 = '0;
  logic cen2 = 1'b1, gwen2 = 1'b1, busy2, done2;
  logic [1:0] wen2 = '1;
  logic [15:0] d2 = '0, q2;
  int checks = 0, failures = 0;
  logic [15:0] m_mem [DEPTH];
  logic [15:0] m_q = '0, m_qo = '0;
  int m_left = DEPTH;
  logic m_done = 1'b0;
  always #5 clk = ~clk;
  ct_spsram_clr dut (
    .CLK(clk), .RST(rst), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(d), .Q(q),
    .CLR_REQ(clr_req), .CLR_BUSY(busy), .CLR_DONE(done)
  );
  ct_spsram_clr #(.WE_WIDTH(2)) dut2 (
    .CLK(clk), .RST(rst), .A(a2), .CEN(cen2), .GWEN(gwen2), .WEN(wen2), .D(d2), .Q(q2),
    .CLR_REQ(1'b0), .CLR_BUSY(busy2), .CLR_DONE(done2)
  );
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    logic was_busy;
    was_busy = m_left > 0;
    m_qo = rst ? '0 : m_q;
    if (rst) begin
      m_left = DEPTH;
      m_q = '0;
      m_done = 1'b0;
    end else begin
      if (!was_busy && !cen) begin
        if (gwen) m_q = m_mem[a];
        else for (int b = 0; b < 16; b++) if (!wen[b/G]) m_mem[a][b] = d[b];
      end
      m_done = 1'b0;
      if (clr_req) m_left = DEPTH;
      else if (was_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          foreach (m_mem[i]) m_mem[i] = '0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
`ifdef CT_SPSRAM_OUTREG_EN
    chk("q", q, m_qo);
`else
    chk("q", q, m_q);
`endif
    chk("busy", {15'd0, busy}, {15'd0, m_left > 0});
    chk("done", {15'd0, done}, {15'd0, m_done});
  endtask
  task automatic lat();
`ifdef CT_SPSRAM_OUTREG_EN
    tick();
`endif
  endtask
  task automatic wr(input logic [6:0] ad, input logic [15:0] dd, input logic [15:0] we);
    a = ad; d = dd; wen = we; cen = 1'b0; gwen = 1'b0;
    tick();
    cen = 1'b1; gwen = 1'b1; wen = '1;
  endtask
  task automatic rd(input string tag, input logic [6:0] ad, input logic [15:0] exp);
    a = ad; cen = 1'b0; gwen = 1'b1;
    tick();
    cen = 1'b1;
    lat();
    chk(tag, q, exp);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) tick();
    chk("clear_timeout", {15'd0, busy}, 16'd0);
  endtask
  initial begin
    foreach (m_mem[i]) m_mem[i] = '0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (127) tick();
    chk("busy_before_last", {15'd0, busy}, 16'd1);
    tick();
    chk("done_at_129", {15'd0, done}, 16'd1);
    rd("rd_7f_init", 7'h7f, 16'h0000);
    a2 = 7'h03; cen2 = 1'b0; gwen2 = 1'b0; d2 = 16'h1234; wen2 = 2'b00;
    tick();
    d2 = 16'hffff; wen2 = 2'b10;
    tick();
    gwen2 = 1'b1;
    tick();
    cen2 = 1'b1;
    lat();
    chk("group_write", q2, 16'h12ff);
    wr(7'h05, 16'habcd, 16'h00ff);
    rd("partial_write", 7'h05, 16'hab00);
    wr(7'h10, 16'h5a5a, 16'h0000);
    rd("fill_10", 7'h10, 16'h5a5a);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("busy_after_req", {15'd0, busy}, 16'd1);
    wr(7'h10, 16'h1111, 16'h0000);
    chk("q_hold_in_clear", q, 16'h5a5a);
    wait_idle();
    rd("reclear_10", 7'h10, 16'h0000);
    wr(7'h20, 16'hc3c3, 16'h0000);
    rd("fill_20", 7'h20, 16'hc3c3);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (49) tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (127) tick();
    chk("no_early_done", {15'd0, done}, 16'd0);
    tick();
    chk("restart_done", {15'd0, done}, 16'd1);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (59) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lat();
    chk("q_after_rst", q, 16'h0000);
    wait_idle();
    for (int n = 0; n < 800; n++) begin
      a = 7'($urandom_range(0, 15));
      cen = $urandom_range(0, 3) == 0;
      gwen = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: wen = '0;
        1: wen = '1;
        default: wen = 16'($urandom);
      endcase
      d = 16'($urandom);
      clr_req = $urandom_range(0, 99) == 0;
      rst = $urandom_range(0, 299) == 0;
      tick();
    end
    rst = 1'b0; clr_req = 1'b0; cen = 1'b1;
    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
